// File: rtl/fft_bar_collector.sv
// Frame sequencer: walks the FFT bins, runs the magnitude/log pipeline per bin
// and writes each result to the bar buffer. Optional macro: FFT_BAR_PEAK_HOLD_EN.
module fft_bar_collector #(
    parameter int N_BINS  = 64,
    parameter int ADDR_W  = 6,
    parameter int RAM_LAT = 1,
    parameter int TIMEOUT = 255,
    parameter int DECAY   = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              FrameStart,
    output logic [ADDR_W-1:0] FftAddr,
    output logic              OptStart,
    input  logic              OptEnd,
    input  logic [6:0]        Spectol,
    output logic              BarWe,
    output logic [ADDR_W-1:0] BarAddr,
    output logic [6:0]        BarData,
    output logic              Busy,
    output logic              FrameDone,
    output logic              Err
);
    // ADDR always lasts at least one cycle, so RAM_LAT=0 behaves like 1
    localparam int LAT_END = (RAM_LAT > 1) ? RAM_LAT : 1;
    localparam int LAT_W   = $clog2(LAT_END + 1);
    localparam int TO_W    = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_BINS - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(LAT_END);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        START,
        WAIT_END,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    state_t            next;
    logic [ADDR_W-1:0] bin;
    logic [LAT_W-1:0]  lat_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [6:0]        result;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:     if (FrameStart) next = ADDR;
            ADDR:     if (lat_cnt == LAT_LAST) next = START;
            START:    next = WAIT_END;
            WAIT_END: if (OptEnd || to_cnt == TO_LAST) next = WRITE;
            WRITE:    next = (bin == LAST_BIN) ? DONE : ADDR;
            DONE:     next = IDLE;
            default:  next = IDLE;
        endcase
    end

    // The bin counter returns to 0 on the last write, so IDLE presents address 0
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            bin     <= '0;
            lat_cnt <= '0;
            to_cnt  <= '0;
            result  <= '0;
            Err     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (FrameStart) begin
                        bin     <= '0;
                        lat_cnt <= LAT_W'(1);
                        Err     <= 1'b0;
                    end
                end
                ADDR: begin
                    lat_cnt <= lat_cnt + LAT_W'(1);
                end
                START: begin
                    to_cnt <= '0;
                end
                WAIT_END: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (OptEnd) begin
                        result <= Spectol;
                    end else if (to_cnt == TO_LAST) begin
                        result <= '0;
                        Err    <= 1'b1;
                    end
                end
                WRITE: begin
                    lat_cnt <= LAT_W'(1);
                    if (bin == LAST_BIN) begin
                        bin <= '0;
                    end else begin
                        bin <= bin + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign FftAddr   = bin;
    assign BarAddr   = bin;
    assign OptStart  = (state == START);
    assign BarWe     = (state == WRITE);
    assign FrameDone = (state == DONE);
    assign Busy      = (state != IDLE) && (state != DONE);

`ifdef FFT_BAR_PEAK_HOLD_EN
    localparam logic [6:0] DECAY7 = 7'(DECAY);

    logic [6:0] peak [N_BINS];
    logic [6:0] decayed;

    always_comb begin
        decayed = (peak[bin] > DECAY7) ? (peak[bin] - DECAY7) : 7'd0;
        BarData = (result > decayed) ? result : decayed;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N_BINS; i++) begin
                peak[i] <= '0;
            end
        end else if (state == WRITE) begin
            peak[bin] <= BarData;
        end
    end
`else
    assign BarData = result;
`endif

endmodule

// File: tb/tb_fft_bar_collector.sv
// Randomized bench for fft_bar_collector: a behavioural pipeline/RAM model
// drives the DUT and a frame-level reference predicts every bar write.
module tb_fft_bar_collector;
    localparam int N   = 64;
    localparam int AW  = 6;
    localparam int LAT = 1;
    localparam int TO  = 255;
    localparam int DEC = 1;

    localparam int N3   = 4;
    localparam int AW3  = 2;
    localparam int LAT3 = 3;
    localparam int TO3  = 20;
    localparam int P3   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          frame_start = 1'b0;
    logic          opt_end = 1'b0;
    logic [6:0]    spectol = '0;
    logic [AW-1:0] fft_addr;
    logic [AW-1:0] bar_addr;
    logic [6:0]    bar_data;
    logic          opt_start, bar_we, busy, frame_done, err;

    logic           frame_start3 = 1'b0;
    logic           opt_end3 = 1'b0;
    logic [6:0]     spectol3 = '0;
    logic [AW3-1:0] fft_addr3;
    logic [AW3-1:0] bar_addr3;
    logic [6:0]     bar_data3;
    logic           opt_start3, bar_we3, busy3, frame_done3, err3;

    fft_bar_collector #(
        .N_BINS(N), .ADDR_W(AW), .RAM_LAT(LAT), .TIMEOUT(TO), .DECAY(DEC)
    ) u_dut (
        .Clock(clk), .Reset(rst), .FrameStart(frame_start),
        .FftAddr(fft_addr), .OptStart(opt_start), .OptEnd(opt_end),
        .Spectol(spectol), .BarWe(bar_we), .BarAddr(bar_addr),
        .BarData(bar_data), .Busy(busy), .FrameDone(frame_done), .Err(err)
    );

    fft_bar_collector #(
        .N_BINS(N3), .ADDR_W(AW3), .RAM_LAT(LAT3), .TIMEOUT(TO3), .DECAY(DEC)
    ) u_lat3 (
        .Clock(clk), .Reset(rst), .FrameStart(frame_start3),
        .FftAddr(fft_addr3), .OptStart(opt_start3), .OptEnd(opt_end3),
        .Spectol(spectol3), .BarWe(bar_we3), .BarAddr(bar_addr3),
        .BarData(bar_data3), .Busy(busy3), .FrameDone(frame_done3), .Err(err3)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int p_lat = 5;
    int drop_bin = -1;
    int overlap = 0;
    int n_ostart = 0;
    int n_done = 0;
    logic [6:0] ram [N];
    logic [6:0] exp_data [N];
    logic [6:0] peak_m [N];
    int wr_addr [$];
    int wr_data [$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Pipeline sees RAM data for the address presented LAT cycles earlier
    task automatic pipe_model();
        int cnt = 0;
        logic [6:0] val = '0;
        int hist [LAT+1];
        foreach (hist[i]) hist[i] = 0;
        forever begin
            @(negedge clk);
            for (int k = LAT; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = int'(fft_addr);
            opt_end = 1'b0;
            if (rst) cnt = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    opt_end = 1'b1;
                    spectol = val;
                end
            end
            if (opt_start) begin
                if (cnt > 0) overlap++;
                if (hist[LAT] != drop_bin) begin
                    cnt = p_lat;
                    val = ram[hist[LAT]];
                end
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (bar_we) begin
                wr_addr.push_back(int'(bar_addr));
                wr_data.push_back(int'(bar_data));
            end
            if (opt_start) n_ostart++;
            if (frame_done) n_done++;
        end
    endtask

    function automatic int model_frame(input int drop);
        int len = 1;
        int r;
`ifdef FFT_BAR_PEAK_HOLD_EN
        int d;
`endif
        for (int i = 0; i < N; i++) begin
            r = (i == drop) ? 0 : int'(ram[i]);
`ifdef FFT_BAR_PEAK_HOLD_EN
            d = int'(peak_m[i]) - DEC;
            if (d < 0) d = 0;
            if (d > r) r = d;
            peak_m[i] = 7'(r);
`endif
            exp_data[i] = 7'(r);
            len += 3 + ((i == drop) ? TO : p_lat);
        end
        return len;
    endfunction

    task automatic randomize_ram();
        foreach (ram[i]) ram[i] = 7'($urandom_range(0, 127));
    endtask

    task automatic run_frame(input bit poke, input int exp_len,
                             output int len, output int busy_bad);
        int start;
        wr_addr.delete();
        wr_data.delete();
        n_ostart = 0;
        n_done = 0;
        overlap = 0;
        busy_bad = 0;
        len = -1;
        @(negedge clk);
        frame_start = 1'b1;
        start = cyc;
        for (int k = 1; k < 5000; k++) begin
            @(negedge clk);
            frame_start = poke && ((k % 10 == 0) || (cyc - start == exp_len));
            if (frame_done) begin
                len = cyc - start;
                if (busy !== 1'b0) busy_bad++;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
        @(negedge clk);
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({fft_addr, opt_start, bar_we, bar_addr, bar_data, busy, frame_done, err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {fft_addr, opt_start, bar_we, bar_addr, bar_data, busy, frame_done, err});
        end
        n_cmp++;
        if ({fft_addr3, opt_start3, bar_we3, bar_addr3, bar_data3, busy3, frame_done3, err3} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_lat3: got %b want all zero",
                     {fft_addr3, opt_start3, bar_we3, bar_addr3, bar_data3, busy3, frame_done3, err3});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, opt_start, bar_we, frame_done, fft_addr} !== '0) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b want all zero",
                     {busy, opt_start, bar_we, frame_done, fft_addr});
        end
    endtask

    task automatic test_ram_lat3();
        logic [6:0] ram3 [N3];
        int hist [LAT3+1];
        int prev = -1, stable = 0, min_stable = 1000, cnt = 0;
        int nw = 0, bad = 0, len = -1, nstart = 0;
        int exp_len = 1 + N3 * (LAT3 + 2 + P3);
        logic [6:0] val = '0;
        foreach (ram3[i]) ram3[i] = 7'($urandom_range(0, 127));
        foreach (hist[i]) hist[i] = 0;
        @(negedge clk);
        frame_start3 = 1'b1;
        for (int k = 1; k < 500; k++) begin
            @(negedge clk);
            frame_start3 = 1'b0;
            stable = (int'(fft_addr3) == prev) ? stable + 1 : 1;
            prev = int'(fft_addr3);
            for (int j = LAT3; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = int'(fft_addr3);
            opt_end3 = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    opt_end3 = 1'b1;
                    spectol3 = val;
                end
            end
            if (opt_start3) begin
                nstart++;
                if (stable - 1 < min_stable) min_stable = stable - 1;
                cnt = P3;
                val = ram3[hist[LAT3]];
            end
            if (bar_we3) begin
                if (nw >= N3 || int'(bar_addr3) != nw || bar_data3 != ram3[nw]) bad++;
                nw++;
            end
            if (frame_done3) begin
                len = k;
                break;
            end
        end
        n_cmp++;
        if (len != exp_len) begin
            n_err++;
            $display("FAIL lat3_frame_len: got %0d want %0d", len, exp_len);
        end
        n_cmp++;
        if (nw != N3 || bad != 0) begin
            n_err++;
            $display("FAIL lat3_writes: got %0d writes (%0d wrong) want %0d (0 wrong)", nw, bad, N3);
        end
        n_cmp++;
        if (nstart != N3) begin
            n_err++;
            $display("FAIL lat3_optstart_count: got %0d want %0d", nstart, N3);
        end
        n_cmp++;
        if (min_stable < LAT3) begin
            n_err++;
            $display("FAIL lat3_addr_stable: got %0d cycles want >= %0d", min_stable, LAT3);
        end
        n_cmp++;
        if (err3 !== 1'b0) begin
            n_err++;
            $display("FAIL lat3_err: got %b want 0", err3);
        end
    endtask

    task automatic test_frame();
        int exp_len, len, bb;
        for (int rep = 0; rep < 2; rep++) begin
            randomize_ram();
            drop_bin = -1;
            exp_len = model_frame(-1);
            run_frame(1'b0, exp_len, len, bb);
            n_cmp++;
            if (len != exp_len) begin
                n_err++;
                $display("FAIL frame_len rep%0d: got %0d want %0d", rep, len, exp_len);
            end
            n_cmp++;
            if (wr_addr.size() != N) begin
                n_err++;
                $display("FAIL write_count rep%0d: got %0d want %0d", rep, wr_addr.size(), N);
            end
            for (int i = 0; i < N && i < wr_addr.size(); i++) begin
                n_cmp++;
                if (wr_addr[i] != i || wr_data[i] != int'(exp_data[i])) begin
                    n_err++;
                    $display("FAIL write rep%0d #%0d: got addr %0d data %0d want addr %0d data %0d",
                             rep, i, wr_addr[i], wr_data[i], i, exp_data[i]);
                end
            end
            n_cmp++;
            if (n_ostart != N || overlap != 0) begin
                n_err++;
                $display("FAIL optstart rep%0d: got %0d starts %0d overlaps want %0d starts 0 overlaps",
                         rep, n_ostart, overlap, N);
            end
            n_cmp++;
            if (bb != 0) begin
                n_err++;
                $display("FAIL busy_window rep%0d: got %0d bad cycles want 0", rep, bb);
            end
            n_cmp++;
            if (err !== 1'b0 || fft_addr !== '0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL idle_after_frame rep%0d: got err %b addr %0d busy %b want 0 0 0",
                         rep, err, fft_addr, busy);
            end
        end
    endtask

    task automatic test_timeout();
        int exp_len, len, bb, bad, got3;
        randomize_ram();
        drop_bin = 3;
        exp_len = model_frame(3);
        run_frame(1'b0, exp_len, len, bb);
        drop_bin = -1;
        n_cmp++;
        if (len != exp_len) begin
            n_err++;
            $display("FAIL timeout_frame_len: got %0d want %0d", len, exp_len);
        end
        got3 = (wr_data.size() > 3) ? wr_data[3] : -1;
        n_cmp++;
        if (got3 != int'(exp_data[3])) begin
            n_err++;
            $display("FAIL timeout_bin3_data: got %0d want %0d", got3, exp_data[3]);
        end
        bad = 0;
        for (int i = 0; i < wr_addr.size() && i < N; i++)
            if (wr_addr[i] != i || wr_data[i] != int'(exp_data[i])) bad++;
        n_cmp++;
        if (wr_addr.size() != N || bad != 0) begin
            n_err++;
            $display("FAIL timeout_writes: got %0d writes (%0d wrong) want %0d (0 wrong)",
                     wr_addr.size(), bad, N);
        end
        n_cmp++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_err_set: got %b want 1", err);
        end
        randomize_ram();
        exp_len = model_frame(-1);
        run_frame(1'b0, exp_len, len, bb);
        n_cmp++;
        if (err !== 1'b0 || len != exp_len) begin
            n_err++;
            $display("FAIL err_cleared: got err %b len %0d want err 0 len %0d", err, len, exp_len);
        end
    endtask

    task automatic test_ignore();
        int exp_len, len, bb, bad;
        randomize_ram();
        exp_len = model_frame(-1);
        run_frame(1'b1, exp_len, len, bb);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (len != exp_len) begin
            n_err++;
            $display("FAIL ignore_frame_len: got %0d want %0d", len, exp_len);
        end
        bad = 0;
        for (int i = 0; i < wr_addr.size() && i < N; i++)
            if (wr_addr[i] != i || wr_data[i] != int'(exp_data[i])) bad++;
        n_cmp++;
        if (wr_addr.size() != N || bad != 0) begin
            n_err++;
            $display("FAIL ignore_writes: got %0d writes (%0d wrong) want %0d (0 wrong)",
                     wr_addr.size(), bad, N);
        end
        n_cmp++;
        if (n_done != 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_done: got %0d done pulses busy %b want 1 done busy 0", n_done, busy);
        end
    endtask

    task automatic test_mid_reset();
        int exp_len, len, bb, found = 0, first;
        randomize_ram();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (opt_start && fft_addr == AW'(20)) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (found != 1) begin
            n_err++;
            $display("FAIL reach_bin20: got found=%0d want 1", found);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || fft_addr !== AW'(20)) begin
            n_err++;
            $display("FAIL wait_bin20: got busy %b addr %0d want busy 1 addr 20", busy, fft_addr);
        end
        #2 rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, opt_start, bar_we, frame_done, fft_addr} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got %b want all zero",
                     {busy, opt_start, bar_we, frame_done, fft_addr});
        end
        foreach (peak_m[i]) peak_m[i] = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        exp_len = model_frame(-1);
        run_frame(1'b0, exp_len, len, bb);
        first = (wr_addr.size() > 0) ? wr_addr[0] : -1;
        n_cmp++;
        if (first != 0 || wr_addr.size() != N || len != exp_len) begin
            n_err++;
            $display("FAIL restart_after_reset: got first %0d writes %0d len %0d want 0 %0d %0d",
                     first, wr_addr.size(), len, N, exp_len);
        end
    endtask

`ifdef FFT_BAR_PEAK_HOLD_EN
    task automatic test_peak();
        int vals [3] = '{100, 0, 120};
        int want [3] = '{100, 99, 120};
        int exp_len, len, bb, got;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        foreach (peak_m[i]) peak_m[i] = '0;
        repeat (2) @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            randomize_ram();
            ram[0] = 7'(vals[f]);
            exp_len = model_frame(-1);
            run_frame(1'b0, exp_len, len, bb);
            got = (wr_data.size() > 0) ? wr_data[0] : -1;
            n_cmp++;
            if (got != want[f]) begin
                n_err++;
                $display("FAIL peak_bin0 frame%0d: got %0d want %0d", f, got, want[f]);
            end
            n_cmp++;
            if (wr_data.size() != N || wr_data[N-1] != int'(exp_data[N-1])) begin
                n_err++;
                $display("FAIL peak_last frame%0d: got %0d writes want %0d with last %0d",
                         f, wr_data.size(), N, exp_data[N-1]);
            end
        end
    endtask
`endif

    initial begin
        foreach (peak_m[i]) peak_m[i] = '0;
        foreach (ram[i]) ram[i] = '0;
        fork
            pipe_model();
            monitor();
        join_none
        test_reset();
        test_ram_lat3();
        test_frame();
        test_timeout();
        test_ignore();
        test_mid_reset();
`ifdef FFT_BAR_PEAK_HOLD_EN
        test_peak();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
